vending_machine_param: RTL and testbench
========================================

Name: vending_machine_param

Overview:
- Parametrised successor to the team's fixed-price vending controller.
- Supports N products, each with its own price, and tracks per-product stock.
- Handles credit accumulation with an overflow cap, rejects excess coins, and returns change.
- Supports cancel/refund, an inactivity timeout refund and a restock command; sits between the coin acceptor front end and the dispenser/change actuators.

Parameters:
NUM_CANS, 4, number of products; legal choices are 0..NUM_CANS-1
CHOICE_W, 2, width of can_choice/can_out; 2**CHOICE_W >= NUM_CANS
CREDIT_W, 4, width of credit, price and change values
MAX_CREDIT, 6, credit ceiling in units; a coin that would exceed it is rejected
PRICE_LIST, {4'd4,4'd3,4'd2,4'd1}, packed prices; price(i) = PRICE_LIST[i*CREDIT_W +: CREDIT_W]
STOCK_W, 3, per-product stock counter width
STOCK_INIT, 5, stock loaded at reset and on restock
TIMEOUT, 16, idle cycles in COLLECT before auto-refund

Ports:
clk  in  1  system clock, rising edge
async_reset_n  in  1  asynchronous active-low reset
coin_in  in  2  0=none, 1=1 unit, 2=2 units, 3=invalid (always rejected)
choose  in  1  single-cycle selection strobe
can_choice  in  CHOICE_W  product index, sampled when choose=1
cancel  in  1  refund request
restock  in  1  reload all stock to STOCK_INIT
can_valid  out  1  one-cycle dispense pulse
can_out  out  CHOICE_W  dispensed product index; valid only while can_valid=1
change_valid  out  1  one-cycle change pulse
change_out  out  CREDIT_W  change amount; valid only while change_valid=1
eject_out  out  1  one-cycle coin-reject pulse
deny  out  1  one-cycle pulse: selection refused
credit  out  CREDIT_W  current credit
sold_out  out  NUM_CANS  bit i=1 when stock(i)==0
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async_reset_n=0, effective immediately):
  - State goes to IDLE, credit=0, timeout counter=0, all stock=STOCK_INIT.
  - All pulse outputs, can_out and change_out are 0; sold_out=0.
- All outputs are registered. Every response appears on the clock edge after the stimulus (1-cycle latency).
- States: IDLE, COLLECT, VEND, CHANGE.
- IDLE:
  - Valid coin: credit=value, go to COLLECT.
  - coin_in=3: eject_out.
  - restock: all stock=STOCK_INIT. restock is ignored in every other state.
  - choose: deny. cancel: ignored.
- COLLECT:
  - Valid coin with credit+value <= MAX_CREDIT: added to credit.
  - Valid coin with credit+value > MAX_CREDIT: eject_out, credit unchanged.
  - choose with can_choice < NUM_CANS, stock>0 and credit >= price: latch the choice, go to VEND.
  - Any other choose: deny, stay in COLLECT.
  - cancel: go to CHANGE.
  - Timeout counter increments each cycle with no coin/choose/cancel and clears on any of them. At TIMEOUT-1, go to CHANGE.
- Simultaneous events in COLLECT:
  - cancel has priority over choose; choose has priority over coin.
  - A coin arriving with choose or cancel is ejected (eject_out) and not credited.
- VEND (1 cycle):
  - can_valid=1, can_out=latched choice, stock of that product decremented, credit -= price.
  - Remaining credit > 0: go to CHANGE. Otherwise go to IDLE.
- CHANGE (1 cycle):
  - change_valid=1, change_out=credit, credit=0, go to IDLE.
- Coins in VEND/CHANGE: ejected. choose in VEND/CHANGE: deny.
- Stock never underflows, because VEND is reachable only with stock>0. sold_out is updated the cycle after the decrement.
- Arithmetic: credit+value is computed in CREDIT_W+1 bits before comparing against MAX_CREDIT, so no wrap-around.
- Reset mid-VEND/CHANGE: no pulse is emitted, and credit is lost by design.

Test Plan:
- Reset, coin 1, choose can 0 (price 1) -> can_valid=1, can_out=0, no change_valid, stock(0)=4, back to IDLE.
- Coins 2,2 then choose can 2 (price 3) -> can_valid with can_out=2, next cycle change_valid=1 with change_out=1, credit=0.
- Coins 2,2,2 then 1 -> fourth coin gives eject_out=1 with credit=6; choose can 3 -> can_out=3, change_out=2.
- Coin 1, choose can 3 -> deny=1, credit stays 1; cancel -> change_out=1; coin 2 then 16 idle cycles -> change_valid with change_out=2.
- Vend can 1 five times (coin 2 each) -> sold_out[1]=1; sixth attempt -> deny and credit retained; cancel, then restock in IDLE -> sold_out[1]=0.
- Coin 2 and choose can 1 in the same cycle with credit 2 -> eject_out plus can_valid, credit 0; async_reset_n low mid-COLLECT -> credit=0 immediately, all stock=5.

Source files
------------

// File: rtl/vending_machine_param.sv
// Parametrised multi-product vending controller: credit collection with a cap,
// per-product stock, change return, cancel/timeout refund and restock.
module vending_machine_param #(
  parameter int unsigned NUM_CANS   = 4,
  parameter int unsigned CHOICE_W   = 2,
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 6,
  parameter logic [NUM_CANS*CREDIT_W-1:0] PRICE_LIST = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter int unsigned STOCK_W    = 3,
  parameter int unsigned STOCK_INIT = 5,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                async_reset_n,
  input  logic [1:0]          coin_in,
  input  logic                choose,
  input  logic [CHOICE_W-1:0] can_choice,
  input  logic                cancel,
  input  logic                restock,
  output logic                can_valid,
  output logic [CHOICE_W-1:0] can_out,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_out,
  output logic                eject_out,
  output logic                deny,
  output logic [CREDIT_W-1:0] credit,
  output logic [NUM_CANS-1:0] sold_out,
  output logic                busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [STOCK_W-1:0]  stock     [NUM_CANS];
  logic [STOCK_W-1:0]  stock_nxt [NUM_CANS];

  logic                can_valid_nxt, change_valid_nxt, eject_nxt, deny_nxt, busy_nxt;
  logic [CHOICE_W-1:0] can_out_nxt;
  logic [CREDIT_W-1:0] change_out_nxt;
  logic [NUM_CANS-1:0] sold_out_nxt;

  logic                coin_valid, coin_any, coin_fits;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                sel_hit, sel_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state        <= IDLE;
      credit       <= '0;
      tmr          <= '0;
      for (int unsigned i = 0; i < NUM_CANS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      can_valid    <= 1'b0;
      can_out      <= '0;
      change_valid <= 1'b0;
      change_out   <= '0;
      eject_out    <= 1'b0;
      deny         <= 1'b0;
      sold_out     <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      tmr          <= tmr_nxt;
      stock        <= stock_nxt;
      can_valid    <= can_valid_nxt;
      can_out      <= can_out_nxt;
      change_valid <= change_valid_nxt;
      change_out   <= change_out_nxt;
      eject_out    <= eject_nxt;
      deny         <= deny_nxt;
      sold_out     <= sold_out_nxt;
      busy         <= busy_nxt;
    end
  end

  always_comb begin
    coin_valid = (coin_in == 2'd1) || (coin_in == 2'd2);
    coin_any   = (coin_in != 2'd0);
    coin_val   = CREDIT_W'(coin_in);
    // Widened by one bit so a near-full credit cannot wrap past the cap.
    coin_sum   = {1'b0, credit} + {1'b0, coin_val};
    coin_fits  = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);

    sel_hit   = 1'b0;
    sel_price = '0;
    sel_stock = '0;
    for (int unsigned i = 0; i < NUM_CANS; i++) begin
      if (CHOICE_W'(i) == can_choice) begin
        sel_hit   = 1'b1;
        sel_price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        sel_stock = stock[i];
      end
    end
    sel_ok = sel_hit && (sel_stock != '0) && (credit >= sel_price);

    for (int unsigned i = 0; i < NUM_CANS; i++) sold_out_nxt[i] = (stock[i] == '0);
  end

  // VEND/CHANGE actions are registered on the edge that enters the state,
  // so each pulse is visible exactly while busy reports that state.
  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    tmr_nxt          = tmr;
    stock_nxt        = stock;
    can_valid_nxt    = 1'b0;
    can_out_nxt      = '0;
    change_valid_nxt = 1'b0;
    change_out_nxt   = '0;
    eject_nxt        = 1'b0;
    deny_nxt         = 1'b0;

    case (state)
      IDLE: begin
        if (coin_valid) begin
          credit_nxt = coin_val;
          tmr_nxt    = '0;
          state_nxt  = COLLECT;
        end else if (coin_any) begin
          eject_nxt = 1'b1;
        end
        if (restock) begin
          for (int unsigned i = 0; i < NUM_CANS; i++) stock_nxt[i] = STOCK_W'(STOCK_INIT);
        end
        if (choose) deny_nxt = 1'b1;
      end

      COLLECT: begin
        if (cancel) begin
          eject_nxt        = coin_any;
          change_valid_nxt = 1'b1;
          change_out_nxt   = credit;
          credit_nxt       = '0;
          tmr_nxt          = '0;
          state_nxt        = CHANGE;
        end else if (choose) begin
          eject_nxt = coin_any;
          tmr_nxt   = '0;
          if (sel_ok) begin
            can_valid_nxt = 1'b1;
            can_out_nxt   = can_choice;
            credit_nxt    = credit - sel_price;
            for (int unsigned i = 0; i < NUM_CANS; i++) begin
              if (CHOICE_W'(i) == can_choice) stock_nxt[i] = stock[i] - 1'b1;
            end
            state_nxt = VEND;
          end else begin
            deny_nxt = 1'b1;
          end
        end else if (coin_any) begin
          tmr_nxt = '0;
          if (coin_valid && coin_fits) credit_nxt = coin_sum[CREDIT_W-1:0];
          else                         eject_nxt  = 1'b1;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          change_valid_nxt = 1'b1;
          change_out_nxt   = credit;
          credit_nxt       = '0;
          tmr_nxt          = '0;
          state_nxt        = CHANGE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      VEND: begin
        eject_nxt = coin_any;
        deny_nxt  = choose;
        if (credit != '0) begin
          change_valid_nxt = 1'b1;
          change_out_nxt   = credit;
          credit_nxt       = '0;
          state_nxt        = CHANGE;
        end else begin
          state_nxt = IDLE;
        end
      end

      CHANGE: begin
        eject_nxt = coin_any;
        deny_nxt  = choose;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == VEND) || (state_nxt == CHANGE);
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed-vector bench for vending_machine_param with hand-computed expectations.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       async_reset_n;
  logic [1:0] coin_in;
  logic       choose;
  logic [1:0] can_choice;
  logic       cancel;
  logic       restock;
  logic       can_valid;
  logic [1:0] can_out;
  logic       change_valid;
  logic [3:0] change_out;
  logic       eject_out;
  logic       deny;
  logic [3:0] credit;
  logic [3:0] sold_out;
  logic       busy;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  vending_machine_param #(
    .NUM_CANS  (4),
    .CHOICE_W  (2),
    .CREDIT_W  (4),
    .MAX_CREDIT(6),
    .PRICE_LIST({4'd4, 4'd3, 4'd2, 4'd1}),
    .STOCK_W   (3),
    .STOCK_INIT(5),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .coin_in      (coin_in),
    .choose       (choose),
    .can_choice   (can_choice),
    .cancel       (cancel),
    .restock      (restock),
    .can_valid    (can_valid),
    .can_out      (can_out),
    .change_valid (change_valid),
    .change_out   (change_out),
    .eject_out    (eject_out),
    .deny         (deny),
    .credit       (credit),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the edge, then clear.
  task automatic step(input logic [1:0] c, input logic ch, input logic [1:0] sel,
                      input logic cn, input logic rs);
    coin_in    = c;
    choose     = ch;
    can_choice = sel;
    cancel     = cn;
    restock    = rs;
    @(posedge clk);
    #1;
    coin_in = 2'd0;
    choose  = 1'b0;
    cancel  = 1'b0;
    restock = 1'b0;
  endtask

  task automatic idle();
    step(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    async_reset_n = 1'b0;
    coin_in = 2'd0; choose = 1'b0; can_choice = 2'd0; cancel = 1'b0; restock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_credit", credit, 0);
    check("rst_sold_out", sold_out, 0);
    check("rst_can_valid", can_valid, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_busy", busy, 0);
    async_reset_n = 1'b1;

    // Exact-price vend of can 0: no change pulse
    step(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t1_credit", credit, 1);
    step(2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t1_can_valid", can_valid, 1);
    check("t1_can_out", can_out, 0);
    check("t1_credit_after", credit, 0);
    check("t1_busy", busy, 1);
    idle();
    check("t1_no_change", change_valid, 0);
    check("t1_back_idle", busy, 0);

    // Vend can 2 with change of 1
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t2_credit", credit, 4);
    step(2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
    check("t2_can_valid", can_valid, 1);
    check("t2_can_out", can_out, 2);
    check("t2_credit_mid", credit, 1);
    idle();
    check("t2_change_valid", change_valid, 1);
    check("t2_change_out", change_out, 1);
    check("t2_credit_zero", credit, 0);
    idle();
    check("t2_idle", busy, 0);

    // Credit cap: fourth coin rejected at credit 6
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t3_credit_cap", credit, 6);
    check("t3_no_eject", eject_out, 0);
    step(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t3_eject", eject_out, 1);
    check("t3_credit_held", credit, 6);
    step(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
    check("t3_can_out", can_out, 3);
    idle();
    check("t3_change_out", change_out, 2);
    idle();

    // Deny on insufficient credit, cancel refund, timeout refund
    step(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
    check("t4_deny", deny, 1);
    check("t4_credit_kept", credit, 1);
    check("t4_no_vend", can_valid, 0);
    step(2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("t4_cancel_change", change_valid, 1);
    check("t4_cancel_out", change_out, 1);
    idle();
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) idle();
    check("t4_pre_timeout", change_valid, 0);
    check("t4_pre_timeout_credit", credit, 2);
    idle();
    check("t4_timeout_change", change_valid, 1);
    check("t4_timeout_out", change_out, 2);
    idle();

    // Invalid coin and choose while idle
    step(2'd3, 1'b1, 2'd0, 1'b0, 1'b0);
    check("idle_bad_coin_eject", eject_out, 1);
    check("idle_choose_deny", deny, 1);
    check("idle_credit", credit, 0);

    // Sell out can 1, sixth attempt denied, restock clears sold_out
    for (int i = 0; i < 5; i++) begin
      step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
      step(2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
      check("t5_vend", can_valid, 1);
      if (i == 4) check("t5_sold_out_lag", sold_out, 0);
      idle();
    end
    check("t5_sold_out", sold_out, 4'b0010);
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    check("t5_deny_sold_out", deny, 1);
    check("t5_credit_retained", credit, 2);
    step(2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("t5_refund", change_out, 2);
    idle();
    step(2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle();
    check("t5_restocked", sold_out, 0);

    // Coin together with a successful choose: coin ejected, vend proceeds
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
    check("t6_eject", eject_out, 1);
    check("t6_can_valid", can_valid, 1);
    check("t6_can_out", can_out, 1);
    check("t6_credit", credit, 0);
    idle();
    check("t6_no_change", change_valid, 0);

    // Drain can 1 again, then reset mid-COLLECT reloads stock immediately
    for (int i = 0; i < 4; i++) begin
      step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
      step(2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
      idle();
    end
    check("t6_drained", sold_out, 4'b0010);
    step(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t6_pre_reset_credit", credit, 1);
    #2;
    async_reset_n = 1'b0;
    #1;
    check("t6_async_credit", credit, 0);
    check("t6_async_sold_out", sold_out, 0);
    async_reset_n = 1'b1;
    step(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    check("t6_stock_reloaded", can_valid, 1);
    check("t6_stock_can_out", can_out, 1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
